// File: rtl/truth_sweep_pkg.sv
// Shared types and width helpers for the truth-table sweeper and its settle timer.
package truth_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_e;

  localparam int N_IN_DEFAULT = 3;
  localparam int NVEC = 2 ** N_IN_DEFAULT;

  function automatic int nvec_of(input int n_in);
    return 2 ** n_in;
  endfunction

  function automatic int idx_width(input int n_in);
    return (n_in < 1) ? 1 : n_in;
  endfunction

  // One extra bit so that every vector mismatching still fits.
  function automatic int mismatch_width(input int n_in);
    return n_in + 1;
  endfunction

  function automatic int settle_width(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that holds each stimulus vector for a programmable number of cycles.
module settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         zero
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= value;
    end else if (en && !zero) begin
      count_reg <= count_reg - ONE;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input vector of a small combinational function, captures its settled
// output into a truth table and counts disagreements with the expected table.
module truth_table_sweeper
  import truth_sweep_pkg::*;
#(
  parameter int                  N_IN     = 3,
  parameter int                  SETTLE   = 2,
  parameter logic [2**N_IN-1:0]  EXPECTED = 8'hE8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  output logic [idx_width(N_IN)-1:0]       abc_out,
  input  logic                             f_in,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic [2**N_IN-1:0]               table_out,
  output logic [mismatch_width(N_IN)-1:0]  mismatch_cnt
);

  localparam int NV = nvec_of(N_IN);
  localparam int IW = idx_width(N_IN);
  localparam int MW = mismatch_width(N_IN);
  localparam int SW = settle_width(SETTLE);
  localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [MW-1:0] MM_ONE   = MW'(1);

  sweep_state_e state_reg, state_next;

  logic [IW-1:0] idx_reg;
  logic [NV-1:0] table_reg;
  logic [MW-1:0] mismatch_reg;

  logic launch, capture, last_vec;
  logic timer_load, timer_en, timer_zero;

  // Vectors run 0..NV-1, so the last one is the all-ones index.
  assign last_vec = &idx_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: if (start) state_next = ST_SETTLE;
      ST_SETTLE:        if (timer_zero) state_next = ST_SAMPLE;
      ST_SAMPLE:        state_next = last_vec ? ST_DONE : ST_SETTLE;
      default:          state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    launch  = 1'b0;
    capture = 1'b0;
    case (state_reg)
      ST_IDLE:   launch = start;
      ST_DONE: begin
        done   = 1'b1;
        launch = start;
      end
      ST_SETTLE: busy = 1'b1;
      ST_SAMPLE: begin
        busy    = 1'b1;
        capture = 1'b1;
      end
      default: ;
    endcase
  end

  assign timer_load = launch | (capture & ~last_vec);
  assign timer_en   = (state_reg == ST_SETTLE);

  settle_timer #(
    .W(SW)
  ) u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .en    (timer_en),
    .value (SETTLE_V),
    .zero  (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg      <= '0;
      table_reg    <= '0;
      mismatch_reg <= '0;
    end else if (launch) begin
      idx_reg      <= '0;
      table_reg    <= '0;
      mismatch_reg <= '0;
    end else if (capture) begin
      table_reg[idx_reg] <= f_in;
      if (f_in != EXPECTED[idx_reg]) mismatch_reg <= mismatch_reg + MM_ONE;
      if (!last_vec) idx_reg <= idx_reg + IDX_ONE;
    end
  end

  assign abc_out      = idx_reg;
  assign table_out    = table_reg;
  assign mismatch_cnt = mismatch_reg;
  assign pass         = done & (mismatch_reg == '0);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized self-checking bench: three sweeper configurations driven by behavioural
// function tables, checked against a truth-table/timing model derived from the rules.
module tb_truth_table_sweeper;

  localparam int K_MAJ = 0;
  localparam int K_XOR = 1;
  localparam int K_AND = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] start_v;
  logic [7:0] fut [3];

  logic [2:0] abc_def, abc_s0;
  logic [1:0] abc_n2;
  logic       busy_def, busy_s0, busy_n2;
  logic       done_def, done_s0, done_n2;
  logic       pass_def, pass_s0, pass_n2;
  logic [7:0] tbl_def, tbl_s0;
  logic [3:0] tbl_n2;
  logic [3:0] mm_def, mm_s0;
  logic [2:0] mm_n2;
  logic       f_def, f_s0, f_n2;

  assign f_def = fut[0][abc_def];
  assign f_s0  = fut[1][abc_s0];
  assign f_n2  = fut[2][{1'b0, abc_n2}];

  logic [2:0] busy_w, done_w, pass_w;
  logic [7:0] table_w [3];
  logic [3:0] mm_w [3];
  logic [2:0] abc_w [3];

  assign busy_w = {busy_n2, busy_s0, busy_def};
  assign done_w = {done_n2, done_s0, done_def};
  assign pass_w = {pass_n2, pass_s0, pass_def};
  assign table_w[0] = tbl_def;
  assign table_w[1] = tbl_s0;
  assign table_w[2] = {4'b0, tbl_n2};
  assign mm_w[0] = mm_def;
  assign mm_w[1] = mm_s0;
  assign mm_w[2] = {1'b0, mm_n2};
  assign abc_w[0] = abc_def;
  assign abc_w[1] = abc_s0;
  assign abc_w[2] = {1'b0, abc_n2};

  truth_table_sweeper #(.N_IN(3), .SETTLE(2), .EXPECTED(8'hE8)) u_def (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abc_out(abc_def), .f_in(f_def),
    .busy(busy_def), .done(done_def), .pass(pass_def), .table_out(tbl_def),
    .mismatch_cnt(mm_def));

  truth_table_sweeper #(.N_IN(3), .SETTLE(0), .EXPECTED(8'hE8)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abc_out(abc_s0), .f_in(f_s0),
    .busy(busy_s0), .done(done_s0), .pass(pass_s0), .table_out(tbl_s0),
    .mismatch_cnt(mm_s0));

  truth_table_sweeper #(.N_IN(2), .SETTLE(2), .EXPECTED(4'h8)) u_n2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abc_out(abc_n2), .f_in(f_n2),
    .busy(busy_n2), .done(done_n2), .pass(pass_n2), .table_out(tbl_n2),
    .mismatch_cnt(mm_n2));

  // Reference configuration of each instance.
  int         nvec_t   [3] = '{8, 8, 4};
  int         settle_t [3] = '{2, 0, 2};
  logic [7:0] expd     [3];

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int popcount(input int v);
    int c = 0;
    for (int b = 0; b < 32; b++) c += (v >> b) & 1;
    return c;
  endfunction

  // Truth table of a named function over n inputs (a = MSB), from its definition.
  function automatic logic [7:0] build_tbl(input int kind, input int n);
    logic [7:0] t = '0;
    for (int i = 0; i < (1 << n); i++) begin
      int ones = popcount(i);
      case (kind)
        K_MAJ:   t[i] = (ones * 2 > n);
        K_XOR:   t[i] = ones[0];
        default: t[i] = (ones == n);
      endcase
    end
    return t;
  endfunction

  // Runs one sweep on instance sel with function table ftbl; optional mid-sweep
  // start pulses (rp1/rp2, cycle offsets), abort by reset at vector abort_idx,
  // and a post-done hold of hold cycles.
  task automatic sweep(input int sel, input logic [7:0] ftbl, input int rp1, input int rp2,
                       input int abort_idx, input int hold);
    int         per     = settle_t[sel] + 2;
    int         total   = nvec_t[sel] * per;
    int         bad_abc = 0;
    int         busy_n  = 0;
    int         bad_hold = 0;
    int         done_at = -1;
    logic [7:0] mask;
    logic [7:0] exp_tbl;
    int         exp_mm;
    mask    = (nvec_t[sel] == 8) ? 8'hFF : 8'h0F;
    exp_tbl = ftbl & mask;
    exp_mm  = popcount(int'((ftbl ^ expd[sel]) & mask));
    fut[sel] = ftbl;
    @(negedge clk) start_v[sel] = 1'b1;
    @(negedge clk) start_v[sel] = 1'b0;
    check("start_clears", int'({table_w[sel], mm_w[sel], done_w[sel]}), 0);
    for (int j = 0; j <= total + 8 && done_at < 0; j++) begin
      if (j > 0) @(negedge clk);
      start_v[sel] = (j == rp1 || j == rp2);
      if (done_w[sel]) begin
        done_at = j;
      end else begin
        if (busy_w[sel]) busy_n++;
        if (pass_w[sel]) bad_abc++;
        if (int'(abc_w[sel]) != j / per) bad_abc++;
        if (abort_idx >= 0 && int'(abc_w[sel]) == abort_idx) begin
          #2 rst_n = 1'b0;
          #1 check("abort_outs", int'({busy_w[sel], done_w[sel], pass_w[sel], table_w[sel],
                                       mm_w[sel], abc_w[sel]}), 0);
          start_v[sel] = 1'b0;
          @(negedge clk) rst_n = 1'b1;
          $display("[TB] inst=%0d sweep aborted by reset at vector %0d", sel, abort_idx);
          return;
        end
      end
    end
    start_v[sel] = 1'b0;
    check("done_time",   done_at, total);
    check("busy_cycles", busy_n, total);
    check("abc_seq",     bad_abc, 0);
    check("table_out",   int'(table_w[sel]), int'(exp_tbl));
    check("mismatch",    int'(mm_w[sel]), exp_mm);
    check("pass",        int'(pass_w[sel]), int'(exp_mm == 0));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!done_w[sel] || busy_w[sel] || table_w[sel] != exp_tbl) bad_hold++;
    end
    if (hold > 0) check("done_hold", bad_hold, 0);
    $display("[TB] inst=%0d f=%02h table=%02h mismatch=%0d pass=%0d done_at=%0d",
             sel, ftbl, table_w[sel], mm_w[sel], pass_w[sel], done_at);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_v = '0;
    fut[0]  = '0;
    fut[1]  = '0;
    fut[2]  = '0;
    expd[0] = build_tbl(K_MAJ, 3);
    expd[1] = build_tbl(K_MAJ, 3);
    expd[2] = build_tbl(K_AND, 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check("rst_abc",   int'(abc_w[s]), 0);
      check("rst_flags", int'({busy_w[s], done_w[s], pass_w[s]}), 0);
      check("rst_table", int'(table_w[s]), 0);
      check("rst_mm",    int'(mm_w[s]), 0);
    end
    repeat (2) @(negedge clk);

    sweep(0, build_tbl(K_MAJ, 3), -1, -1, -1, 0);
    sweep(0, build_tbl(K_XOR, 3), -1, -1, -1, 20);
    sweep(0, build_tbl(K_MAJ, 3), 10, 20, -1, 0);
    sweep(0, 8'($urandom_range(0, 255)), -1, -1, 5, 0);
    sweep(0, build_tbl(K_MAJ, 3), -1, -1, -1, 0);
    sweep(1, build_tbl(K_MAJ, 3), -1, -1, -1, 0);
    sweep(1, build_tbl(K_XOR, 3), -1, -1, -1, 3);
    sweep(2, build_tbl(K_AND, 2), -1, -1, -1, 2);
    for (int r = 0; r < 9; r++) begin
      sweep(r % 3, 8'($urandom_range(0, 255)),
            ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : -1, -1, -1,
            int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
